// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the RV M funct3 op encodings, the FSM state encoding and the
// helpers that classify which operands of an op are signed.
package mdu_iter_pkg;

    localparam logic [2:0] MDU_OP_MUL    = 3'd0;
    localparam logic [2:0] MDU_OP_MULH   = 3'd1;
    localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [2:0] MDU_OP_DIV    = 3'd4;
    localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [2:0] MDU_OP_REM    = 3'd6;
    localparam logic [2:0] MDU_OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_sign_fix.sv
// Result fix-up for the multiply/divide unit (purely combinational).
// Applies the recorded two's-complement negate and selects the result:
//   acc_i    : 2*XLEN accumulator; product for multiplies,
//              {remainder, quotient} for divides
//   op_i     : captured RV M funct3
//   neg_i    : negate flag recorded at capture
//   result_o : final XLEN-bit result
module mdu_iter_sign_fix
    import mdu_iter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [2:0]        op_i,
    input  logic              neg_i,
    output logic [XLEN-1:0]   result_o
);

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    always_comb begin
        prod = neg_i ? (~acc_i + 1'b1) : acc_i;
        quot = neg_i ? (~acc_i[XLEN-1:0] + 1'b1) : acc_i[XLEN-1:0];
        rem  = neg_i ? (~acc_i[2*XLEN-1:XLEN] + 1'b1) : acc_i[2*XLEN-1:XLEN];
        result_o = '0;
        case (op_i)
            MDU_OP_MUL:                           result_o = prod[XLEN-1:0];
            MDU_OP_MULH, MDU_OP_MULHSU,
            MDU_OP_MULHU:                         result_o = prod[2*XLEN-1:XLEN];
            MDU_OP_DIV, MDU_OP_DIVU:              result_o = quot;
            default:                              result_o = rem;
        endcase
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit.
// One request in (valid/ready), one response out (valid/ready).
//   clk_i, rst_ni              : clock, async active-low reset
//   req_valid_i/req_ready_o    : request handshake; op_i, op1_i, op2_i captured
//   flush_i                    : kill the in-flight operation, no response
//   resp_valid_o/resp_ready_i  : response handshake; result_o valid with resp_valid_o
//   busy_o                     : high whenever not IDLE (execute-stage stall)
//   dbg_state_o                : current FSM state
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised by the unit, stays high with stable data
// until the transfer (or a flush).
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o,
    output logic [2:0]      dbg_state_o
);

    localparam int MUL_N = XLEN / MUL_BITS;
    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_e state_q, state_d;

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   b_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    logic            accept;
    logic            sa, sb;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, div_ovf;
    logic            neg_d;

    logic [XLEN+MUL_BITS-1:0] mul_sum;
    logic [XLEN:0]            div_shift, div_diff;
    logic [2*XLEN-1:0]        mul_next, div_next;
    logic [XLEN-1:0]          fix_result;

    // Capture-side decode: absolute values, negate flag and special cases.
    always_comb begin
        sa       = op_signed_a(op_i) && op1_i[XLEN-1];
        sb       = op_signed_b(op_i) && op2_i[XLEN-1];
        a_abs    = sa ? (~op1_i + 1'b1) : op1_i;
        b_abs    = sb ? (~op2_i + 1'b1) : op2_i;
        div_zero = op_i[2] && (op2_i == '0);
        div_ovf  = ((op_i == MDU_OP_DIV) || (op_i == MDU_OP_REM)) &&
                   (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        case (op_i)
            MDU_OP_MULH, MDU_OP_DIV: neg_d = sa ^ sb;
            MDU_OP_MULHSU, MDU_OP_REM: neg_d = sa;
            default: neg_d = 1'b0;
        endcase
    end

    // Shift-add step: multiplier sits in the low half of acc and is consumed
    // MUL_BITS at a time while the partial product grows into the high half.
    always_comb begin
        mul_sum  = (XLEN+MUL_BITS)'(acc_q[2*XLEN-1:XLEN]) +
                   (XLEN+MUL_BITS)'(b_q) * (XLEN+MUL_BITS)'(acc_q[MUL_BITS-1:0]);
        mul_next = {mul_sum, acc_q[XLEN-1:MUL_BITS]};
    end

    // Restoring division step: acc holds {remainder, dividend/quotient}.
    always_comb begin
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (!div_diff[XLEN])
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    mdu_iter_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .acc_i    (acc_q),
        .op_i     (op_q),
        .neg_i    (neg_q),
        .result_o (fix_result)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Special cases skip iteration; they pass through FIX with the answer
    // pre-loaded into acc so the normal select produces it.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    accept = 1'b1;
                    if (div_zero || div_ovf) state_d = ST_FIX;
                    else if (op_i[2])        state_d = ST_DIV;
                    else                     state_d = ST_MUL;
                end
            end
            ST_MUL, ST_DIV: if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (resp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= MDU_OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q <= op_i;
            b_q  <= b_abs;
            if (div_zero) begin
                acc_q <= {op1_i, {XLEN{1'b1}}};
                neg_q <= 1'b0;
            end else if (div_ovf) begin
                acc_q <= {{XLEN{1'b0}}, op1_i};
                neg_q <= 1'b0;
            end else begin
                acc_q <= {{XLEN{1'b0}}, a_abs};
                neg_q <= neg_d;
            end
            cnt_q <= op_i[2] ? CNT_W'(XLEN - 1) : CNT_W'(MUL_N - 1);
        end else begin
            case (state_q)
                ST_MUL: begin
                    acc_q <= mul_next;
                    cnt_q <= cnt_q - 1'b1;
                end
                ST_DIV: begin
                    acc_q <= div_next;
                    cnt_q <= cnt_q - 1'b1;
                end
                ST_FIX: result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign result_o     = result_q;
    assign dbg_state_o  = state_q;

endmodule
